// File: rtl/xdisplay_mux_if.sv
// Display controller bus: digit writes, blink/brightness controls and the
// registered pin outputs.
interface xdisplay_mux_if #(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned SEG_W    = 8,
  parameter int unsigned AW       = 2
);
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [SEG_W-1:0]    wr_data;
  logic [N_DIGITS-1:0] blink_mask;
  logic [3:0]          bright;
  logic [N_DIGITS-1:0] an_n;
  logic [SEG_W-1:0]    seg_n;
  logic [AW-1:0]       digit_idx;

  modport master (
    output wr_en, wr_addr, wr_data, blink_mask, bright,
    input  an_n, seg_n, digit_idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, blink_mask, bright,
    output an_n, seg_n, digit_idx
  );
endinterface

// File: rtl/xdisplay_mux.sv
// Multiplexed N-digit seven-segment driver with addressed writes, blank
// interval, 16-level PWM brightness and per-digit blink.
module xdisplay_mux #(
  parameter int unsigned N_DIGITS  = 4,
  parameter int unsigned SEG_W     = 8,
  parameter int unsigned SCAN_DIV  = 262144,
  parameter int unsigned BLANK_CYC = 16,
  parameter int unsigned BLINK_DIV = 16777216,
  parameter int unsigned AW        = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic           clk,
  input  logic           rst,
  xdisplay_mux_if.slave  bus
);

  localparam int unsigned SCAN_W  = $clog2(SCAN_DIV);
  localparam int unsigned BLINK_W = $clog2(BLINK_DIV);

  logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [SEG_W-1:0]    digit_q [N_DIGITS];
  logic [SEG_W-1:0]    digit_d [N_DIGITS];

  // First output stage: slot decision taken from the live scan state.
  logic                s1_on_q, s1_on_d;
  logic [AW-1:0]       s1_idx_q, s1_idx_d;
  logic [SEG_W-1:0]    s1_seg_q, s1_seg_d;

  logic [N_DIGITS-1:0] an_n_q, an_n_d;
  logic [SEG_W-1:0]    seg_n_q, seg_n_d;
  logic [AW-1:0]       digit_idx_q, digit_idx_d;

  always_comb begin
    scan_cnt_d    = scan_cnt_q + SCAN_W'(1);
    idx_d         = idx_q;
    blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
    blink_phase_d = blink_phase_q;
    digit_d       = digit_q;

    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == AW'(N_DIGITS - 1)) ? '0 : idx_q + AW'(1);
    end

    if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end

    // Out-of-range addresses match no register and are dropped.
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (bus.wr_en && (bus.wr_addr == AW'(i))) digit_d[i] = bus.wr_data;
    end

    s1_on_d  = !((scan_cnt_q < SCAN_W'(BLANK_CYC)) ||
                 (scan_cnt_q[3:0] > bus.bright) ||
                 (blink_phase_q && bus.blink_mask[idx_q]));
    s1_idx_d = idx_q;
    s1_seg_d = digit_q[idx_q];

    an_n_d      = s1_on_q ? ~(N_DIGITS'(1) << s1_idx_q) : '1;
    seg_n_d     = s1_on_q ? s1_seg_q : '1;
    digit_idx_d = s1_idx_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q    <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      digit_q       <= '{default: '1};
      s1_on_q       <= 1'b0;
      s1_idx_q      <= '0;
      s1_seg_q      <= '1;
      an_n_q        <= '1;
      seg_n_q       <= '1;
      digit_idx_q   <= '0;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      digit_q       <= digit_d;
      s1_on_q       <= s1_on_d;
      s1_idx_q      <= s1_idx_d;
      s1_seg_q      <= s1_seg_d;
      an_n_q        <= an_n_d;
      seg_n_q       <= seg_n_d;
      digit_idx_q   <= digit_idx_d;
    end
  end

  assign bus.an_n      = an_n_q;
  assign bus.seg_n     = seg_n_q;
  assign bus.digit_idx = digit_idx_q;

endmodule

// File: tb/tb_xdisplay_mux.sv
// Randomised bench for xdisplay_mux against a cycle-count reference model.
module tb_xdisplay_mux;

  localparam int N     = 4;
  localparam int SDIV  = 32;
  localparam int BLANK = 4;
  localparam int BDIV  = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;

  xdisplay_mux_if #(.N_DIGITS(N), .SEG_W(8), .AW(2)) dif ();

  xdisplay_mux #(
    .N_DIGITS(N), .SEG_W(8), .SCAN_DIV(SDIV), .BLANK_CYC(BLANK),
    .BLINK_DIV(BDIV), .AW(2)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: c = edges since reset release; outputs trail the state by two edges.
  int         c;
  logic [7:0] mdig [N];
  logic [3:0] e1_an, e2_an;
  logic [7:0] e1_seg, e2_seg;
  logic [1:0] e1_idx, e2_idx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t c=%0d got=%h exp=%h", tag, $time, c, got, exp);
    end
  endtask

  task automatic reset_model();
    c = 0;
    for (int i = 0; i < N; i++) mdig[i] = 8'hFF;
    e1_an = 4'hF; e2_an = 4'hF;
    e1_seg = 8'hFF; e2_seg = 8'hFF;
    e1_idx = 2'd0; e2_idx = 2'd0;
  endtask

  task automatic tick();
    int sc, ix, ph;
    bit off;
    @(posedge clk);
    e2_an  = e1_an;
    e2_seg = e1_seg;
    e2_idx = e1_idx;
    sc  = c % SDIV;
    ix  = (c / SDIV) % N;
    ph  = (c / BDIV) % 2;
    off = (sc < BLANK) || ((sc % 16) > int'(dif.bright)) ||
          ((ph == 1) && dif.blink_mask[ix]);
    e1_an  = off ? 4'hF : (4'hF & ~(4'h1 << ix));
    e1_seg = off ? 8'hFF : mdig[ix];
    e1_idx = 2'(ix);
    if (dif.wr_en) mdig[dif.wr_addr] = dif.wr_data;
    c++;
    @(negedge clk);
    chk("an_n", 32'(dif.an_n), 32'(e2_an));
    chk("seg_n", 32'(dif.seg_n), 32'(e2_seg));
    chk("digit_idx", 32'(dif.digit_idx), 32'(e2_idx));
    chk("one_an", 32'($countones(~dif.an_n) <= 1), 32'd1);
  endtask

  task automatic write(input logic [1:0] a, input logic [7:0] d);
    dif.wr_en = 1'b1; dif.wr_addr = a; dif.wr_data = d;
    tick();
    dif.wr_en = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_until(input int modv, input int target);
    for (int i = 0; i < 4 * SDIV * N && (c % modv) != target; i++) tick();
    chk("align", 32'(c % modv), 32'(target));
  endtask

  initial begin
    dif.wr_en = 1'b0; dif.wr_addr = '0; dif.wr_data = '0;
    dif.blink_mask = 4'b0000; dif.bright = 4'd15;
    reset_model();
    repeat (2) @(negedge clk);
    chk("rst_an", 32'(dif.an_n), 32'hF);
    chk("rst_seg", 32'(dif.seg_n), 32'hFF);
    chk("rst_idx", 32'(dif.digit_idx), 32'd0);
    rst = 1'b0;

    // Basic scan with the four reference patterns, beyond one full wrap
    write(2'd0, 8'hC0);
    write(2'd1, 8'hF9);
    write(2'd2, 8'hA4);
    write(2'd3, 8'hB0);
    run(300);

    // Addressed write mid-slot 0
    run_until(SDIV * N, 12);
    write(2'd2, 8'h92);
    run(140);

    // Write to the digit currently displayed
    run_until(SDIV, 10);
    write(2'((c / SDIV) % N), 8'h80);
    run(40);

    // Reduced brightness
    dif.bright = 4'd3;
    run(200);
    dif.bright = 4'd15;

    // Blink on digit 1 across several blink periods
    dif.blink_mask = 4'b0010;
    run(700);
    dif.blink_mask = 4'b0000;

    // Randomised writes, brightness and blink masks
    for (int i = 0; i < 2000; i++) begin
      if (i % 64 == 0)  dif.bright = 4'($urandom_range(15, 0));
      if (i % 300 == 0) dif.blink_mask = 4'($urandom_range(15, 0));
      if ($urandom_range(7, 0) == 0) write(2'($urandom_range(3, 0)), 8'($urandom));
      else tick();
    end

    // Asynchronous reset mid-slot at digit 2, scan_cnt 20
    dif.bright = 4'd15; dif.blink_mask = 4'b0000;
    run_until(SDIV * N, 2 * SDIV + 20);
    rst = 1'b1;
    #1;
    chk("arst_an", 32'(dif.an_n), 32'hF);
    chk("arst_seg", 32'(dif.seg_n), 32'hFF);
    chk("arst_idx", 32'(dif.digit_idx), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    run(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
